waitstate_controller: RTL

- Multi-channel, run-time configurable wait state generator for the MAXI030 bus glue, one instance serving all decoded peripheral chip selects.
- Each channel is either fixed-count (wait for N clocks) or ready-terminated (wait for at least N clocks and then for a device ready).
- A bus watchdog ends any cycle that is held too long and flags a timeout, which the glue turns into a bus error.

---
 rtl/waitstate_pkg.sv | 13 +
 rtl/waitstate_config_regs.sv | 43 ++++
 rtl/waitstate_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/waitstate_pkg.sv
// waitstate_pkg: shared FSM/mode types and the chip-select priority encoder
// Contents: state_e, mode_e, MAX_CHANNELS, lowest_set()
package waitstate_pkg;
    typedef enum logic [2:0] {IDLE, COUNT, WAIT_READY, DONE, FAULT} state_e;
    typedef enum logic {MODE_FIXED = 1'b0, MODE_READY = 1'b1} mode_e;
    localparam int MAX_CHANNELS = 16;
    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_CHANNELS-1:0] v);
        lowest_set = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--)
            if (v[i]) lowest_set = 4'(i);
    endfunction
endpackage

// File: rtl/waitstate_config_regs.sv
// waitstate_config_regs: per-channel delay/mode register file
// Ports: i_clock, i_reset_n (async, active-low) | i_write, i_wr_channel, i_wr_delay,
//        i_wr_mode: write port | i_rd_channel -> o_rd_delay, o_rd_mode: combinational read
module waitstate_config_regs
    import waitstate_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] DEFAULT_DELAY = 4'h1,
    localparam int CW = $clog2(CHANNELS)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_write,
    input  logic [CW-1:0]    i_wr_channel,
    input  logic [WIDTH-1:0] i_wr_delay,
    input  mode_e            i_wr_mode,
    input  logic [CW-1:0]    i_rd_channel,
    output logic [WIDTH-1:0] o_rd_delay,
    output mode_e            o_rd_mode
);
    logic [WIDTH-1:0] r_delay [CHANNELS];
    mode_e            r_mode  [CHANNELS];
    logic             w_wr_ok;

    // Writes addressing a channel that does not exist are dropped.
    assign w_wr_ok = i_write && (32'(i_wr_channel) < CHANNELS);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_delay[i] <= DEFAULT_DELAY;
                r_mode[i]  <= MODE_FIXED;
            end
        end else if (w_wr_ok) begin
            r_delay[i_wr_channel] <= i_wr_delay;
            r_mode[i_wr_channel]  <= i_wr_mode;
        end
    end

    assign o_rd_delay = r_delay[i_rd_channel];
    assign o_rd_mode  = r_mode[i_rd_channel];
endmodule

// File: rtl/waitstate_controller.sv
// waitstate_controller: multi-channel configurable wait state generator with bus watchdog
// Ports: i_clock, i_reset_n (async, active-low) | i_cs, i_ext_ready: per-channel select/ready
//        i_cfg_write, i_cfg_channel, i_cfg_delay, i_cfg_mode: config write port
//        o_waitstate: extend cycle | o_timeout: watchdog fired | o_active_channel: latched channel
module waitstate_controller
    import waitstate_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] DEFAULT_DELAY = 4'h1,
    parameter int TIMEOUT_WIDTH = 8,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT = 8'hFF,
    localparam int CW = $clog2(CHANNELS)
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_cs,
    input  logic [CHANNELS-1:0] i_ext_ready,
    input  logic                i_cfg_write,
    input  logic [CW-1:0]       i_cfg_channel,
    input  logic [WIDTH-1:0]    i_cfg_delay,
    input  logic                i_cfg_mode,
    output logic                o_waitstate,
    output logic                o_timeout,
    output logic [CW-1:0]       o_active_channel
);
    if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("CHANNELS must be in 2..16");
    end
    // The counter stops at D, so the watchdog must outlast the longest fixed count.
    if (int'(TIMEOUT) <= 2**WIDTH - 1) begin : g_bad_timeout
        $error("TIMEOUT must exceed 2**WIDTH-1");
    end

    state_e                   r_state, w_state_nx;
    logic [CW-1:0]            r_chan, w_chan_nx;
    logic [WIDTH-1:0]         r_delay, w_delay_nx;
    mode_e                    r_mode, w_mode_nx;
    logic [WIDTH-1:0]         r_count, w_count_nx;
    logic [TIMEOUT_WIDTH-1:0] r_wdog, w_wdog_nx;
    logic                     w_any, w_start, w_count_hit, w_waitstate, w_timeout;
    logic [CW-1:0]            w_sel;
    logic [WIDTH-1:0]         w_live_delay;
    mode_e                    w_live_mode;

    waitstate_config_regs #(
        .CHANNELS      (CHANNELS),
        .WIDTH         (WIDTH),
        .DEFAULT_DELAY (DEFAULT_DELAY)
    ) u_regs (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_write      (i_cfg_write),
        .i_wr_channel (i_cfg_channel),
        .i_wr_delay   (i_cfg_delay),
        .i_wr_mode    (mode_e'(i_cfg_mode)),
        .i_rd_channel (w_sel),
        .o_rd_delay   (w_live_delay),
        .o_rd_mode    (w_live_mode)
    );

    assign w_any       = |i_cs;
    assign w_sel       = CW'(lowest_set(MAX_CHANNELS'(i_cs)));
    // A new cycle starts from IDLE, or when a different channel takes over with no gap.
    assign w_start     = w_any && (r_state == IDLE || w_sel != r_chan);
    assign w_count_hit = r_count == r_delay;

    always_comb begin
        w_state_nx  = r_state;
        w_chan_nx   = r_chan;
        w_delay_nx  = r_delay;
        w_mode_nx   = r_mode;
        w_count_nx  = r_count;
        w_wdog_nx   = r_wdog;
        w_waitstate = 1'b0;
        w_timeout   = 1'b0;
        if (!w_any) begin
            w_state_nx = IDLE;
            w_count_nx = '0;
            w_wdog_nx  = '0;
        end else if (w_start) begin
            w_waitstate = w_live_delay != '0;
            w_chan_nx   = w_sel;
            w_delay_nx  = w_live_delay;
            w_mode_nx   = w_live_mode;
            w_count_nx  = WIDTH'(1);
            w_wdog_nx   = TIMEOUT_WIDTH'(1);
            w_state_nx  = w_live_delay != '0 ? COUNT : w_live_mode == MODE_READY ? WAIT_READY : DONE;
        end else begin
            case (r_state)
                COUNT: begin
                    // A fixed-count cycle releases the bus combinationally once the count is met.
                    w_waitstate = !w_count_hit || r_mode == MODE_READY;
                    w_count_nx  = w_count_hit ? r_count : r_count + 1'b1;
                    w_state_nx  = !w_count_hit ? COUNT : r_mode == MODE_READY ? WAIT_READY : DONE;
                end
                WAIT_READY: begin
                    w_waitstate = 1'b1;
                    w_state_nx  = i_ext_ready[r_chan] ? DONE : WAIT_READY;
                end
                FAULT:   w_timeout = 1'b1;
                default: w_waitstate = 1'b0;
            endcase
            // The watchdog overrides any other transition on the edge it expires.
            if (r_state == COUNT || r_state == WAIT_READY) begin
                w_wdog_nx = r_wdog + 1'b1;
                if (w_wdog_nx == TIMEOUT) w_state_nx = FAULT;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_chan  <= '0;
            r_delay <= '0;
            r_mode  <= MODE_FIXED;
            r_count <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_chan  <= w_chan_nx;
            r_delay <= w_delay_nx;
            r_mode  <= w_mode_nx;
            r_count <= w_count_nx;
            r_wdog  <= w_wdog_nx;
        end
    end

    assign o_waitstate      = i_reset_n && w_waitstate;
    assign o_timeout        = i_reset_n && w_timeout;
    assign o_active_channel = r_chan;
endmodule
